// File: rtl/c16_snd_if.sv
// c16 peripheral write port as seen by the sound block.
// The c16 output registers drive it as master; c16_snd consumes it as slave.
interface c16_snd_if;
  logic        snd_wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;

  modport master (output snd_wen, w_param, w_index, w_val);
  modport slave  (input  snd_wen, w_param, w_index, w_val);
endinterface

// File: rtl/c16_snd.sv
// c16_snd: per-channel tone registers, square-wave generators with duration
// timers and a registered level mix. Optional PWM DAC output under C16_SND_PWM_EN.
module c16_snd #(
  parameter int NCH      = 4,
  parameter int TONE_DIV = 50,
  parameter int DUR_DIV  = 50000
) (
  input  logic           clk,
  input  logic           resetn,
  c16_snd_if.slave       wr,
  output logic [5:0]     snd_level,
  output logic [NCH-1:0] snd_active
`ifdef C16_SND_PWM_EN
  ,
  output logic           snd_pwm
`endif
);

  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int DW = (DUR_DIV > 1) ? $clog2(DUR_DIV) : 1;

  // Write port: a write is taken on every clk edge where snd_wen is high;
  // there is no ready, so every strobe (including back-to-back) is accepted.
  logic wr_hit;
  assign wr_hit = wr.snd_wen && (wr.w_index < 11'(NCH));

  logic [TW-1:0] tone_div;
  logic [DW-1:0] dur_div;
  logic          tone_tick;
  logic          dur_tick;

  assign tone_tick = (tone_div == TW'(TONE_DIV - 1));
  assign dur_tick  = (dur_div == DW'(DUR_DIV - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tone_div <= '0;
      dur_div  <= '0;
    end else begin
      tone_div <= tone_tick ? '0 : tone_div + 1'b1;
      dur_div  <= dur_tick ? '0 : dur_div + 1'b1;
    end
  end

  logic [NCH-1:0]   en_v;
  logic [NCH*4-1:0] contrib;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [15:0] period;
    logic [3:0]  vol;
    logic [15:0] dur;
    logic        en;
    logic [15:0] cnt;
    logic        phase;
    logic        sel;
    logic        wr_per, wr_vol, wr_dur, wr_ctl;
    logic        tick_run, dur_run, expire;

    assign sel    = wr_hit && (wr.w_index[1:0] == 2'(c));
    assign wr_per = sel && (wr.w_param == 2'd0);
    assign wr_vol = sel && (wr.w_param == 2'd1);
    assign wr_dur = sel && (wr.w_param == 2'd2);
    assign wr_ctl = sel && (wr.w_param == 2'd3);

    assign tick_run = tone_tick && en && (period != 16'd0);
    assign dur_run  = dur_tick && en && (dur != 16'd0);
    // A same-cycle duration write replaces the decrement, so no expiry then.
    assign expire   = dur_run && (dur == 16'd1) && !wr_dur;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        period <= '0;
        vol    <= '0;
        dur    <= '0;
        en     <= 1'b0;
        cnt    <= '0;
        phase  <= 1'b0;
      end else begin
        if (wr_per) period <= wr.w_val;
        if (wr_vol) vol <= wr.w_val[3:0];

        if (wr_dur)       dur <= wr.w_val;
        else if (dur_run) dur <= dur - 16'd1;

        if (wr_ctl)      en <= wr.w_val[0];
        else if (expire) en <= 1'b0;

        // >= lets a period rewritten below the running count wrap on the next tick.
        if (wr_ctl && wr.w_val[1]) begin
          cnt   <= '0;
          phase <= 1'b0;
        end else if (tick_run) begin
          if (cnt >= period - 16'd1) begin
            cnt   <= '0;
            phase <= ~phase;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      end
    end

    assign en_v[c]          = en;
    assign contrib[c*4 +: 4] = (en && phase && (period != 16'd0)) ? vol : 4'd0;
  end

  logic [5:0] mix_sum;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      mix_sum = mix_sum + 6'(contrib[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snd_level  <= '0;
      snd_active <= '0;
    end else begin
      snd_level  <= mix_sum;
      snd_active <= en_v;
    end
  end

`ifdef C16_SND_PWM_EN
  logic [5:0] pwm_cnt;

  // 60-step frame so that full-scale level 60 holds the output high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
      snd_pwm <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == 6'd59) ? 6'd0 : pwm_cnt + 6'd1;
      snd_pwm <= (pwm_cnt < snd_level);
    end
  end
`endif

endmodule

// File: tb/tb_c16_snd.sv
// Self-checking bench for c16_snd: behavioural model with an expected-output
// queue, directed scenarios with literal expectations, then random writes.
module tb_c16_snd;
  localparam int NCH      = 4;
  localparam int TONE_DIV = 2;
  localparam int DUR_DIV  = 10;
  localparam int W        = 11;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  c16_snd_if bus ();

  logic [5:0]     snd_level;
  logic [NCH-1:0] snd_active;
  logic           pwm_out;
`ifdef C16_SND_PWM_EN
  logic           snd_pwm;
  assign pwm_out = snd_pwm;
`else
  assign pwm_out = 1'b0;
`endif

  c16_snd #(.NCH(NCH), .TONE_DIV(TONE_DIV), .DUR_DIV(DUR_DIV)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr         (bus),
    .snd_level  (snd_level),
    .snd_active (snd_active)
`ifdef C16_SND_PWM_EN
    ,
    .snd_pwm    (snd_pwm)
`endif
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_per[NCH], m_vol[NCH], m_dur[NCH], m_cnt[NCH];
  bit  m_en[NCH], m_ph[NCH];
  int  m_level = 0;
  longint edge_k = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NCH; c++) begin
        m_per[c] = 0; m_vol[c] = 0; m_dur[c] = 0; m_cnt[c] = 0;
        m_en[c] = 0; m_ph[c] = 0;
      end
      m_level = 0;
      edge_k  = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      bit tt, dt, pwm_bit, hit;
      int lvl, prm, val;
      logic [NCH-1:0] act;
      edge_k++;
      tt = ((edge_k - 1) % TONE_DIV) == TONE_DIV - 1;
      dt = ((edge_k - 1) % DUR_DIV) == DUR_DIV - 1;
      pwm_bit = ((edge_k - 1) % 60) < m_level;
      lvl = 0;
      for (int c = 0; c < NCH; c++) begin
        if (m_en[c] && m_ph[c] && m_per[c] != 0) lvl += m_vol[c];
        act[c] = m_en[c];
      end
      prm = int'(bus.w_param);
      val = int'(bus.w_val);
      for (int c = 0; c < NCH; c++) begin
        bit oe; int od, op;
        oe = m_en[c]; od = m_dur[c]; op = m_per[c];
        hit = bus.snd_wen && (int'(bus.w_index) == c);
        if (hit && prm == 3 && val[1]) begin
          m_cnt[c] = 0; m_ph[c] = 0;
        end else if (tt && oe && op != 0) begin
          if (m_cnt[c] >= op - 1) begin m_cnt[c] = 0; m_ph[c] = !m_ph[c]; end
          else m_cnt[c] = m_cnt[c] + 1;
        end
        if (hit && prm == 2) m_dur[c] = val;
        else if (dt && oe && od != 0) m_dur[c] = od - 1;
        if (hit && prm == 3) m_en[c] = val[0];
        else if (dt && oe && od == 1 && !(hit && prm == 2)) m_en[c] = 0;
        if (hit && prm == 0) m_per[c] = val;
        if (hit && prm == 1) m_vol[c] = val & 15;
      end
      m_level = lvl;
`ifdef C16_SND_PWM_EN
      exp_q.push_back({pwm_bit, act, 6'(lvl)});
`else
      exp_q.push_back({1'b0, act, 6'(lvl)});
`endif
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("level", int'(snd_level), int'(e[5:0]));
    check("active", int'(snd_active), int'(e[9:6]));
    check("pwm", int'(pwm_out), int'(e[10]));
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int idx, input int prm, input int val);
    bus.snd_wen = 1'b1;
    bus.w_index = 11'(idx);
    bus.w_param = 2'(prm);
    bus.w_val   = 16'(val);
    @(negedge clk);
    bus.snd_wen = 1'b0;
  endtask

  task automatic wait_level(input int tgt);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int'(snd_level) == tgt) begin ok = 1; break; end
    end
    check($sformatf("reach_level_%0d", tgt), int'(ok), 1);
  endtask

  task automatic freeze_high(input int ch, input int tgt);
    wr(ch, 1, 15);
    wr(ch, 0, 2);
    wr(ch, 3, 3);
    wait_level(tgt);
    wr(ch, 0, 16'hFFFF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi_cnt, mx, nz, ones;
    bus.snd_wen = 1'b0;
    bus.w_param = '0;
    bus.w_index = '0;
    bus.w_val   = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("rst_level", int'(snd_level), 0);
    check("rst_active", int'(snd_active), 0);

    // ch0 square wave, period 3 ticks
    wr(0, 0, 3);
    wr(0, 1, 15);
    wr(0, 3, 3);
    repeat (2) @(negedge clk);
    check("tone_active", int'(snd_active), 1);
    repeat (8) @(negedge clk);
    hi_cnt = 0; mx = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (snd_level == 6'd15) hi_cnt++;
      if (int'(snd_level) > mx) mx = int'(snd_level);
    end
    check("tone_high_cycles", hi_cnt, 12);
    check("tone_max", mx, 15);

    // asynchronous reset mid-cycle while ch0 runs
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("midrst_level", int'(snd_level), 0);
    check("midrst_active", int'(snd_active), 0);
    check("midrst_pwm", int'(pwm_out), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (snd_level != 0 || snd_active != 0) nz++;
    end
    check("post_rst_quiet", nz, 0);

    // duration auto-stop
    wr(0, 2, 2);
    wr(0, 1, 5);
    wr(0, 0, 1);
    wr(0, 3, 1);
    repeat (3) @(negedge clk);
    check("dur_active_on", int'(snd_active), 1);
    repeat (40) @(negedge clk);
    check("dur_active_off", int'(snd_active), 0);
    check("dur_level_off", int'(snd_level), 0);

    // all channels full volume
    for (int c = 0; c < NCH; c++) begin
      wr(c, 1, 15);
      wr(c, 0, 4);
    end
    for (int c = 0; c < NCH; c++) wr(c, 3, 3);
    mx = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(snd_level) > mx) mx = int'(snd_level);
    end
    check("all_max_level", mx, 60);
    check("all_active", int'(snd_active), 15);

    // out-of-range indices are ignored
    for (int c = 0; c < NCH; c++) wr(c, 3, 2);
    wr(4, 3, 1);
    wr(11'h7FF, 3, 1);
    wr(4, 0, 1);
    wr(11'h7FF, 1, 9);
    repeat (3) @(negedge clk);
    check("bad_idx_active", int'(snd_active), 0);
    check("bad_idx_level", int'(snd_level), 0);

    // randomized writes against the model
    for (int i = 0; i < 1500; i++) begin
      int idx, prm, val;
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 3));
      prm = int'($urandom_range(0, 3));
      case (prm)
        0: val = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 5));
        1: val = int'($urandom_range(0, 65535));
        2: val = int'($urandom_range(0, 4));
        default: val = int'($urandom_range(0, 3));
      endcase
      wr(idx, prm, val);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef C16_SND_PWM_EN
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    freeze_high(0, 15);
    freeze_high(1, 30);
    repeat (3) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pwm_out) ones++;
    end
    check("pwm_duty_30", ones, 30);
    freeze_high(2, 45);
    freeze_high(3, 60);
    repeat (3) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pwm_out) ones++;
    end
    check("pwm_duty_60", ones, 60);
`else
    ones = 0;
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
